// File: rtl/ibex_multdiv_iter_pkg.sv
// Shared types for the iterative multiply/divide unit.
package ibex_multdiv_iter_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_PREP = 3'd1,
    MD_ITER = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_iter_state_e;

  // Request attributes captured at accept.
  typedef struct packed {
    md_op_e     op;
    logic [1:0] signed_mode;
    logic       data_ind;
  } md_ctrl_t;

  function automatic logic md_is_div(md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/ibex_multdiv_iter_step.sv
// One iteration of the multiply/divide datapath: BitsPerCycle shift-add or
// restoring-subtract stages cascaded combinationally.
module ibex_multdiv_iter_step #(
  parameter int unsigned Width        = 32,
  parameter int unsigned BitsPerCycle = 1
) (
  input  logic               is_div_i,
  input  logic [2*Width-1:0] acc_i,   // product, or partial remainder in [Width:0]
  input  logic [2*Width-1:0] opa_i,   // multiplicand, or dividend/quotient in [Width-1:0]
  input  logic [Width-1:0]   opb_i,   // multiplier, or divisor
  output logic [2*Width-1:0] acc_o,
  output logic [2*Width-1:0] opa_o,
  output logic [Width-1:0]   opb_o
);

  logic [2*Width-1:0] acc_v;
  logic [2*Width-1:0] opa_v;
  logic [Width-1:0]   opb_v;
  logic [Width:0]     rem_sh;
  logic [Width+1:0]   diff;

  // Cascade the per-bit stages; the divisor borrow decides restore vs. keep.
  always_comb begin
    acc_v  = acc_i;
    opa_v  = opa_i;
    opb_v  = opb_i;
    rem_sh = '0;
    diff   = '0;
    for (int i = 0; i < int'(BitsPerCycle); i++) begin
      if (is_div_i) begin
        rem_sh = {acc_v[Width-1:0], opa_v[Width-1]};
        diff   = {1'b0, rem_sh} - {2'b00, opb_v};
        if (!diff[Width+1]) begin
          acc_v = {{(Width-1){1'b0}}, diff[Width:0]};
        end else begin
          acc_v = {{(Width-1){1'b0}}, rem_sh};
        end
        opa_v = {opa_v[2*Width-2:0], ~diff[Width+1]};
      end else begin
        if (opb_v[0]) begin
          acc_v = acc_v + opa_v;
        end
        opa_v = opa_v << 1;
        opb_v = opb_v >> 1;
      end
    end
    acc_o = acc_v;
    opa_o = opa_v;
    opb_o = opb_v;
  end

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply/divide unit with valid/ready on both sides, kill,
// divide special-case fast paths and optional multiply early exit.
module ibex_multdiv_iter
  import ibex_multdiv_iter_pkg::*;
#(
  parameter int unsigned Width        = 32,
  parameter int unsigned BitsPerCycle = 1,
  parameter bit          EarlyExit    = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  md_op_e           operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  input  logic             data_ind_timing_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned NumIter = Width / BitsPerCycle;
  localparam int unsigned CntW    = $clog2(NumIter + 1);
  localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

  if ((Width < 8) || ((Width % 2) != 0)) begin : g_bad_width
    $error("ibex_multdiv_iter: Width must be even and at least 8");
  end
  if (!((BitsPerCycle == 1) || (BitsPerCycle == 2) || (BitsPerCycle == 4) ||
        (BitsPerCycle == 8)) || ((Width % BitsPerCycle) != 0)) begin : g_bad_bpc
    $error("ibex_multdiv_iter: BitsPerCycle must be 1, 2, 4 or 8 and divide Width");
  end

  md_iter_state_e     state_q, state_d;
  md_ctrl_t           ctrl_q, ctrl_d;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [2*Width-1:0] opa_q, opa_d;
  logic [Width-1:0]   opb_q, opb_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               special_q, special_d;
  logic [Width-1:0]   result_q, result_d;

  logic [2*Width-1:0] step_acc, step_opa;
  logic [Width-1:0]   step_opb;
  logic               is_div;
  logic [Width-1:0]   a_raw, b_raw, mag_a, mag_b;
  logic               a_neg, b_neg, div_zero, div_ovf;
  logic [Width-1:0]   special_res, fix_res;
  logic [2*Width-1:0] prod_s;

  assign is_div   = md_is_div(ctrl_q.op);
  assign a_raw    = opa_q[Width-1:0];
  assign b_raw    = opb_q;
  assign a_neg    = ctrl_q.signed_mode[0] & a_raw[Width-1];
  assign b_neg    = ctrl_q.signed_mode[1] & b_raw[Width-1];
  assign mag_a    = a_neg ? -a_raw : a_raw;
  assign mag_b    = b_neg ? -b_raw : b_raw;
  assign div_zero = (b_raw == '0);
  assign div_ovf  = (ctrl_q.signed_mode == 2'b11) && (a_raw == MinVal) && (b_raw == '1);

  ibex_multdiv_iter_step #(
    .Width        (Width),
    .BitsPerCycle (BitsPerCycle)
  ) u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .opa_i    (opa_q),
    .opb_i    (opb_q),
    .acc_o    (step_acc),
    .opa_o    (step_opa),
    .opb_o    (step_opb)
  );

  // Divide-by-zero and signed-overflow results, taken from the raw operands.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = (ctrl_q.op == MD_OP_DIV) ? '1 : a_raw;
    end else if (div_ovf) begin
      special_res = (ctrl_q.op == MD_OP_DIV) ? a_raw : '0;
    end
  end

  // Sign-correct the iterated result and select the requested half/part.
  always_comb begin
    prod_s  = neg_q ? -acc_q : acc_q;
    fix_res = '0;
    unique case (ctrl_q.op)
      MD_OP_MULL: fix_res = prod_s[Width-1:0];
      MD_OP_MULH: fix_res = prod_s[2*Width-1:Width];
      MD_OP_DIV:  fix_res = neg_q ? -opa_q[Width-1:0] : opa_q[Width-1:0];
      MD_OP_REM:  fix_res = neg_q ? -acc_q[Width-1:0] : acc_q[Width-1:0];
      default:    fix_res = '0;
    endcase
  end

  // Next-state and datapath update; kill overrides every transition.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    special_d = special_q;
    result_d  = result_q;
    unique case (state_q)
      MD_IDLE: begin
        if (valid_i && ready_o) begin
          state_d = MD_PREP;
          ctrl_d  = '{op: operator_i, signed_mode: signed_mode_i, data_ind: data_ind_timing_i};
          opa_d   = {{Width{1'b0}}, op_a_i};
          opb_d   = op_b_i;
        end
      end
      MD_PREP: begin
        acc_d     = '0;
        opa_d     = {{Width{1'b0}}, mag_a};
        opb_d     = mag_b;
        cnt_d     = CntW'(NumIter);
        special_d = 1'b0;
        neg_d     = (ctrl_q.op == MD_OP_REM) ? a_neg : (a_neg ^ b_neg);
        state_d   = MD_ITER;
        if (is_div && (div_zero || div_ovf)) begin
          result_d = special_res;
          if (ctrl_q.data_ind) begin
            special_d = 1'b1;
          end else begin
            state_d = MD_DONE;
          end
        end
      end
      MD_ITER: begin
        acc_d = step_acc;
        opa_d = step_opa;
        opb_d = step_opb;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = MD_FIX;
        end else if (EarlyExit && !is_div && !ctrl_q.data_ind && (step_opb == '0)) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        if (!special_q) begin
          result_d = fix_res;
        end
        state_d = MD_DONE;
      end
      MD_DONE: begin
        if (ready_i) begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
    if (kill_i && (state_q != MD_IDLE)) begin
      state_d = MD_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= MD_IDLE;
      ctrl_q    <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = (state_q == MD_IDLE) && !kill_i;
  assign valid_o  = (state_q == MD_DONE);
  assign busy_o   = (state_q != MD_IDLE);
  assign result_o = result_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Self-checking bench: three instances (32/1 no early exit, 32/1 early exit,
// 32/4 early exit) driven with shared inputs, checked against an arithmetic model.
module tb_ibex_multdiv_iter;
  import ibex_multdiv_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, kill_i, ready_i, dit_i;
  md_op_e      op_i;
  logic [1:0]  sm_i;
  logic [31:0] a_i, b_i;
  logic        rdy[3], vo[3], busy[3];
  logic [31:0] res[3];
  logic [31:0] last_res[3];
  int          passed = 0, failed = 0, total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ibex_multdiv_iter #(
      .Width        (32),
      .BitsPerCycle ((g == 2) ? 4 : 1),
      .EarlyExit    ((g == 0) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .valid_i           (valid_i),
      .ready_o           (rdy[g]),
      .operator_i        (op_i),
      .signed_mode_i     (sm_i),
      .op_a_i            (a_i),
      .op_b_i            (b_i),
      .data_ind_timing_i (dit_i),
      .kill_i            (kill_i),
      .valid_o           (vo[g]),
      .ready_i           (ready_i),
      .result_o          (res[g]),
      .busy_o            (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result from plain 64-bit arithmetic on the extended operands.
  function automatic logic [31:0] ref_result(md_op_e op, logic [1:0] sm, logic [31:0] a,
                                             logic [31:0] b);
    longint ea, eb, p;
    logic   ovf;
    ea  = sm[0] ? longint'($signed(a)) : longint'(a);
    eb  = sm[1] ? longint'($signed(b)) : longint'(b);
    ovf = (sm == 2'b11) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    case (op)
      MD_OP_MULL: begin p = ea * eb; return p[31:0]; end
      MD_OP_MULH: begin p = ea * eb; return p[63:32]; end
      MD_OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = ea / eb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = ea % eb;
        return p[31:0];
      end
    endcase
  endfunction

  // Cycles from accept to valid_o for instance i.
  function automatic int exp_lat(int i, md_op_e op, logic [1:0] sm, logic [31:0] a,
                                 logic [31:0] b, logic dit);
    int          bpc, bl, k;
    logic [31:0] mag;
    bpc = (i == 2) ? 4 : 1;
    if ((op == MD_OP_DIV || op == MD_OP_REM) && !dit &&
        (b == 0 || (sm == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 2;
    if ((op == MD_OP_MULL || op == MD_OP_MULH) && (i != 0) && !dit) begin
      mag = (sm[1] && b[31]) ? -b : b;
      bl  = 0;
      while (mag != 0) begin bl++; mag = mag >> 1; end
      k = (bl + bpc - 1) / bpc;
      if (k < 1) k = 1;
      return k + 3;
    end
    return 32 / bpc + 3;
  endfunction

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s valid_o u%0d", tag, i), 64'(vo[i]), 64'd0);
      chk($sformatf("%s result_o u%0d", tag, i), 64'(res[i]), 64'd0);
      chk($sformatf("%s busy_o u%0d", tag, i), 64'(busy[i]), 64'd0);
      chk($sformatf("%s ready_o u%0d", tag, i), 64'(rdy[i]), 64'd1);
    end
  endtask

  task automatic start_op(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                          input logic [31:0] b, input logic dit);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 20) begin @(negedge clk); n++; end
    chk("ready_o before accept", 64'(rdy[0] && rdy[1] && rdy[2]), 64'd1);
    op_i = op; sm_i = sm; a_i = a; b_i = b; dit_i = dit; valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    a_i = $urandom; b_i = $urandom;
  endtask

  task automatic wait_all(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                          input logic [31:0] b, input logic dit);
    logic [2:0]  got;
    int          lat;
    logic [31:0] er;
    got = 3'b000;
    er  = ref_result(op, sm, a, b);
    lat = 1;
    while (got != 3'b111 && lat < 100) begin
      for (int i = 0; i < 3; i++) begin
        if (!got[i] && vo[i]) begin
          got[i]      = 1'b1;
          last_res[i] = res[i];
          chk($sformatf("result u%0d op%0d %h/%h", i, op, a, b), 64'(res[i]), 64'(er));
          chk($sformatf("latency u%0d op%0d dit%0d", i, op, dit), 64'(lat),
              64'(exp_lat(i, op, sm, a, b, dit)));
        end
      end
      if (got != 3'b111) begin @(posedge clk); #1; lat++; end
    end
    for (int i = 0; i < 3; i++)
      if (!got[i]) chk($sformatf("valid_o timeout u%0d", i), 64'd0, 64'd1);
  endtask

  task automatic run_op(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                        input logic [31:0] b, input logic dit, input logic [31:0] kexp);
    start_op(op, sm, a, b, dit);
    wait_all(op, sm, a, b, dit);
    for (int i = 0; i < 3; i++)
      chk($sformatf("directed u%0d op%0d", i, op), 64'(last_res[i]), 64'(kexp));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    md_op_e      rop;
    logic [1:0]  rsm;
    logic [31:0] ra, rb;
    logic        rdit;
    int          vcnt[3];
    logic [31:0] held[3];

    rst = 1'b1; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1; dit_i = 1'b0;
    op_i = MD_OP_MULL; sm_i = 2'b00; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases from the feature list.
    run_op(MD_OP_MULL, 2'b11, 32'd7, -32'sd3, 1'b0, 32'hFFFF_FFEB);
    run_op(MD_OP_MULL, 2'b00, 32'd5, 32'd3, 1'b0, 32'd15);
    run_op(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000);
    run_op(MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFF);
    run_op(MD_OP_DIV, 2'b00, 32'd100, 32'd0, 1'b0, 32'hFFFF_FFFF);
    run_op(MD_OP_REM, 2'b00, 32'd100, 32'd0, 1'b0, 32'd100);
    run_op(MD_OP_DIV, 2'b00, 32'd100, 32'd0, 1'b1, 32'hFFFF_FFFF);
    run_op(MD_OP_REM, 2'b00, 32'd100, 32'd0, 1'b1, 32'd100);
    run_op(MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000);
    run_op(MD_OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);
    run_op(MD_OP_DIV, 2'b11, -32'sd7, 32'd2, 1'b0, 32'hFFFF_FFFD);
    run_op(MD_OP_REM, 2'b11, -32'sd7, 32'd2, 1'b0, 32'hFFFF_FFFF);

    // Random operations against the model.
    for (int t = 0; t < 40; t++) begin
      rop  = md_op_e'(2'($urandom_range(0, 3)));
      rsm  = 2'($urandom_range(0, 3));
      ra   = pick();
      rb   = pick();
      rdit = ($urandom_range(0, 3) == 0);
      start_op(rop, rsm, ra, rb, rdit);
      wait_all(rop, rsm, ra, rb, rdit);
    end

    // Kill in ITER: busy drops next cycle and no result ever appears.
    start_op(MD_OP_MULL, 2'b00, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("kill busy_o u%0d", i), 64'(busy[i]), 64'd0);
      vcnt[i] = 0;
    end
    repeat (50) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (vo[i]) vcnt[i]++;
    end
    for (int i = 0; i < 3; i++) chk($sformatf("kill valid_o count u%0d", i), 64'(vcnt[i]), 64'd0);

    // Backpressure: result and valid hold while ready_i is low.
    ready_i = 1'b0;
    start_op(MD_OP_DIV, 2'b11, -32'sd7, 32'd2, 1'b0);
    wait_all(MD_OP_DIV, 2'b11, -32'sd7, 32'd2, 1'b0);
    for (int i = 0; i < 3; i++) held[i] = last_res[i];
    repeat (5) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("hold valid_o u%0d", i), 64'(vo[i]), 64'd1);
        chk($sformatf("hold result_o u%0d", i), 64'(res[i]), 64'(held[i]));
      end
    end
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("release valid_o u%0d", i), 64'(vo[i]), 64'd0);

    // Reset pulse mid-ITER returns every output to its reset value.
    start_op(MD_OP_MULH, 2'b11, 32'hDEAD_BEEF, 32'h7654_3210, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset mid-iter");
    @(negedge clk);
    rst = 1'b0;
    run_op(MD_OP_MULL, 2'b00, 32'd6, 32'd7, 1'b0, 32'd42);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
